// File: rtl/sample_capture_buffer.sv
// sample_capture_buffer
// Captures sample_data on each sample_ce pulse while armed. Captured words
// go into a 2^DEPTH_LOG2-entry first-word-fall-through FIFO, which drains on a
// valid/ready stream. When a capture arrives and the FIFO is full with no pop
// in the same cycle, the sample is dropped and counted in a saturating
// overflow counter.
// Optional feature macro: SAMPLE_CAPTURE_TIMESTAMP_EN. When it is defined,
// each sample is stored with the free-running cycle-counter value from its
// capture edge.
module sample_capture_buffer #(
    parameter int DWIDTH     = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int TS_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_ce,
    input  logic [DWIDTH-1:0]     sample_data,
    input  logic                  enable,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DWIDTH-1:0]     m_data,
    output logic [TS_WIDTH-1:0]   m_ts,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic [15:0]           overflow_cnt,
    output logic                  busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [DEPTH_LOG2-1:0]   wr_ptr_reg;
    logic [DEPTH_LOG2-1:0]   rd_ptr_reg;
    logic [DEPTH_LOG2:0]     level_reg;
    logic [15:0]             ovf_reg;
    logic [DWIDTH-1:0]       data_mem [DEPTH];

    logic push;
    logic pop;
    logic drop;
    logic fifo_empty;
    logic fifo_full;

    // Occupancy flags derive from the registered level.
    assign fifo_empty = (level_reg == '0);
    assign fifo_full  = (level_reg == FULL_LEVEL);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a capture while it is being read.
    assign pop  = !fifo_empty && m_ready;
    assign push = (state_reg == RUN) && sample_ce && (!fifo_full || pop);
    assign drop = (state_reg == RUN) && sample_ce && fifo_full && !pop;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and busy flag. FLUSH ignores enable, so the block
    // can only be re-armed from IDLE.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (fifo_empty) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read/write pointers wrap naturally at the FIFO depth. The level counter
    // changes only when exactly one of push and pop happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + (DEPTH_LOG2 + 1)'(1);
                2'b01:   level_reg <= level_reg - (DEPTH_LOG2 + 1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Saturating count of samples dropped because the FIFO was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= '0;
        end else if (drop && (ovf_reg != 16'hFFFF)) begin
            ovf_reg <= ovf_reg + 16'd1;
        end
    end

    // Sample storage. It has no reset because contents matter only below the
    // level count.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= sample_data;
        end
    end

    // The head entry is read asynchronously, so a capture appears on the
    // stream in the cycle right after its capture edge. The head is masked
    // to zero while the FIFO is empty.
    assign m_data = fifo_empty ? '0 : data_mem[rd_ptr_reg];

`ifdef SAMPLE_CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt_reg;
    logic [TS_WIDTH-1:0] ts_mem [DEPTH];

    // Free-running cycle counter. It starts from reset and wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt_reg <= '0;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + TS_WIDTH'(1);
        end
    end

    // Each stored timestamp sits alongside its sample and holds the counter
    // value from the capture edge.
    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr_reg] <= ts_cnt_reg;
        end
    end

    assign m_ts = fifo_empty ? '0 : ts_mem[rd_ptr_reg];
`else
    assign m_ts = '0;
`endif

    assign m_valid      = !fifo_empty;
    assign level        = level_reg;
    assign full         = fifo_full;
    assign empty        = fifo_empty;
    assign overflow_cnt = ovf_reg;

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Self-checking bench for sample_capture_buffer. It runs directed scenarios
// plus a randomized run, all compared against a queue-based reference model.
module tb_sample_capture_buffer;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;
`ifdef SAMPLE_CAPTURE_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        sample_ce;
    logic [15:0] sample_data;
    logic        enable;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [31:0] m_ts;
    logic [4:0]  level;
    logic        full;
    logic        empty;
    logic [15:0] overflow_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model: queued words and timestamps, drop count, mode, cycle count
    logic [15:0] mq[$];
    logic [31:0] tq[$];
    logic [15:0] ovf_model;
    int          mode;
    logic [31:0] ts_model;

    sample_capture_buffer #(
        .DWIDTH(16),
        .DEPTH_LOG2(4),
        .TS_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_ce(sample_ce),
        .sample_data(sample_data),
        .enable(enable),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_ts(m_ts),
        .level(level),
        .full(full),
        .empty(empty),
        .overflow_cnt(overflow_cnt),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic model_clear();
        mq.delete();
        tq.delete();
        ovf_model = 16'h0;
        mode      = M_IDLE;
        ts_model  = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        sample_ce = 1'b0;
        sample_data = 16'h0;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // Drive one cycle of inputs, let one clock edge pass, and advance the model.
    task automatic step(input logic ce, input logic [15:0] d, input logic rdy);
        bit pop_m;
        bit push_m;
        bit drop_m;
        int n;
        sample_ce = ce;
        sample_data = d;
        m_ready = rdy;
        n = mq.size();
        pop_m  = (n != 0) && rdy;
        push_m = (mode == M_RUN) && ce && ((n < 16) || pop_m);
        drop_m = (mode == M_RUN) && ce && (n == 16) && !pop_m;
        @(posedge clk);
        #1;
        if (pop_m) begin
            void'(mq.pop_front());
            void'(tq.pop_front());
        end
        if (push_m) begin
            mq.push_back(d);
            tq.push_back(ts_model);
        end
        if (drop_m && (ovf_model != 16'hFFFF)) ovf_model = ovf_model + 16'd1;
        case (mode)
            M_IDLE:  if (enable) mode = M_RUN;
            M_RUN:   if (!enable) mode = M_FLUSH;
            default: if (n == 0) mode = M_IDLE;
        endcase
        ts_model = ts_model + 32'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        sample_ce = 1'b0;
        sample_data = 16'h0;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        checks += 8;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        if (m_data !== 16'h0) begin errors++; $display("FAIL reset_m_data: got %0h expected 0", m_data); end
        if (m_ts !== 32'h0) begin errors++; $display("FAIL reset_m_ts: got %0h expected 0", m_ts); end
        if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        if (overflow_cnt !== 16'h0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", overflow_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_basic();
        int max_level;
        do_reset();
        enable = 1'b1;
        step(1'b0, 16'h0, 1'b1);
        max_level = 0;
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 16'(k), 1'b1);
            checks += 2;
            if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_valid beat %0d: got %b expected 1", k, m_valid); end
            if (m_data !== 16'(k)) begin errors++; $display("FAIL basic_data beat %0d: got %0h expected %0h", k, m_data, k); end
            if (int'(level) > max_level) max_level = int'(level);
            for (int j = 0; j < 9; j++) begin
                step(1'b0, 16'h0, 1'b1);
                if (int'(level) > max_level) max_level = int'(level);
            end
            checks++;
            if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_drained beat %0d: got %b expected 0", k, m_valid); end
        end
        checks++;
        if (max_level !== 1) begin errors++; $display("FAIL basic_max_level: got %0d expected 1", max_level); end
    endtask

    task automatic test_overflow();
        do_reset();
        enable = 1'b1;
        step(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'(i), 1'b0);
            if (i == 14) begin
                checks++;
                if (full !== 1'b0) begin errors++; $display("FAIL ovf_not_full_15: got %b expected 0", full); end
            end
            if (i == 15) begin
                checks += 2;
                if (full !== 1'b1) begin errors++; $display("FAIL ovf_full_16: got %b expected 1", full); end
                if (level !== 5'd16) begin errors++; $display("FAIL ovf_level_16: got %0d expected 16", level); end
            end
        end
        checks += 2;
        if (overflow_cnt !== 16'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", overflow_cnt); end
        if (level !== 5'd16) begin errors++; $display("FAIL ovf_level_after: got %0d expected 16", level); end
        for (int i = 0; i < 16; i++) begin
            checks += 2;
            if (m_valid !== 1'b1) begin errors++; $display("FAIL ovf_drain_valid %0d: got %b expected 1", i, m_valid); end
            if (m_data !== 16'(i)) begin errors++; $display("FAIL ovf_drain_data %0d: got %0h expected %0h", i, m_data, i); end
            step(1'b0, 16'h0, 1'b1);
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained_empty: got %b expected 1", empty); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        enable = 1'b1;
        step(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
        step(1'b1, 16'hABCD, 1'b1);
        checks += 4;
        if (level !== 5'd16) begin errors++; $display("FAIL fpp_level: got %0d expected 16", level); end
        if (full !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b expected 1", full); end
        if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL fpp_ovf: got %0d expected 0", overflow_cnt); end
        if (m_data !== 16'h0101) begin errors++; $display("FAIL fpp_head: got %0h expected 101", m_data); end
        for (int i = 1; i < 16; i++) begin
            checks++;
            if (m_data !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL fpp_drain %0d: got %0h expected %0h", i, m_data, 16'h0100 + 16'(i)); end
            step(1'b0, 16'h0, 1'b1);
        end
        checks++;
        if (m_data !== 16'hABCD) begin errors++; $display("FAIL fpp_last: got %0h expected abcd", m_data); end
        step(1'b0, 16'h0, 1'b1);
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL fpp_empty: got %b expected 1", empty); end
    endtask

    task automatic test_flush();
        do_reset();
        enable = 1'b1;
        step(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h00F0 + 16'(i), 1'b0);
        enable = 1'b0;
        step(1'b0, 16'h0, 1'b1);
        checks += 3;
        if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy0: got %b expected 1", busy); end
        if (level !== 5'd2) begin errors++; $display("FAIL flush_level0: got %0d expected 2", level); end
        if (m_data !== 16'h00F1) begin errors++; $display("FAIL flush_data1: got %0h expected f1", m_data); end
        step(1'b1, 16'hDEAD, 1'b1);
        checks += 2;
        if (level !== 5'd1) begin errors++; $display("FAIL flush_level1: got %0d expected 1", level); end
        if (m_data !== 16'h00F2) begin errors++; $display("FAIL flush_data2: got %0h expected f2", m_data); end
        step(1'b1, 16'hBEEF, 1'b1);
        checks += 2;
        if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", empty); end
        if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_at_empty: got %b expected 1", busy); end
        step(1'b1, 16'hCAFE, 1'b0);
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_fall: got %b expected 0", busy); end
        if (level !== 5'd0) begin errors++; $display("FAIL flush_no_capture: got %0d expected 0", level); end
        if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL flush_ovf: got %0d expected 0", overflow_cnt); end
        // A full FIFO in FLUSH must neither capture nor count drops.
        enable = 1'b1;
        step(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0);
        enable = 1'b0;
        step(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h5555, 1'b0);
        checks += 3;
        if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL flush_full_ovf: got %0d expected 0", overflow_cnt); end
        if (level !== 5'd16) begin errors++; $display("FAIL flush_full_level: got %0d expected 16", level); end
        if (busy !== 1'b1) begin errors++; $display("FAIL flush_full_busy: got %b expected 1", busy); end
        for (int i = 0; i < 17; i++) step(1'b0, 16'h0, 1'b1);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_full_idle: got %b expected 0", busy); end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1;
        step(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 16'(i), 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 16'h0, 1'b1);
        m_ready = 1'b0;
        checks += 2;
        if (level !== 5'd7) begin errors++; $display("FAIL arst_pre_level: got %0d expected 7", level); end
        if (overflow_cnt !== 16'd4) begin errors++; $display("FAIL arst_pre_ovf: got %0d expected 4", overflow_cnt); end
        #2;
        rst = 1'b1;
        #1;
        checks += 6;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", m_valid); end
        if (level !== 5'd0) begin errors++; $display("FAIL arst_level: got %0d expected 0", level); end
        if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL arst_ovf: got %0d expected 0", overflow_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
        if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b expected 1", empty); end
        if (m_data !== 16'h0) begin errors++; $display("FAIL arst_data: got %0h expected 0", m_data); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        enable = 1'b0;
        model_clear();
        step(1'b1, 16'h7777, 1'b0);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL arst_idle: got %b expected 0", busy); end
        if (level !== 5'd0) begin errors++; $display("FAIL arst_idle_capture: got %0d expected 0", level); end
    endtask

    task automatic test_timestamp();
        logic [31:0] first_ts;
        do_reset();
        enable = 1'b1;
        while (ts_model != 32'd100) step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'h1111, 1'b0);
        while (ts_model != 32'd130) step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'h2222, 1'b0);
        first_ts = m_ts;
        checks++;
        if (m_ts !== (TS_ON ? 32'd100 : 32'd0)) begin errors++; $display("FAIL ts_first: got %0d expected %0d", m_ts, TS_ON ? 100 : 0); end
        step(1'b0, 16'h0, 1'b1);
        checks += 2;
        if (m_data !== 16'h2222) begin errors++; $display("FAIL ts_second_data: got %0h expected 2222", m_data); end
        if ((m_ts - first_ts) !== (TS_ON ? 32'd30 : 32'd0)) begin errors++; $display("FAIL ts_delta: got %0d expected %0d", m_ts - first_ts, TS_ON ? 30 : 0); end
    endtask

    task automatic test_random();
        int pct;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [31:0] exp_ts;
        logic [4:0]  exp_level;
        do_reset();
        enable = 1'b1;
        pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 200) == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 10;
                    1:       pct = 50;
                    default: pct = 95;
                endcase
            end
            if ($urandom_range(0, 99) < 3) enable = ~enable;
            step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, 16'($urandom),
                 ($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0);
            exp_valid = (mq.size() != 0);
            exp_data  = exp_valid ? mq[0] : 16'h0;
            exp_ts    = (exp_valid && TS_ON) ? tq[0] : 32'h0;
            exp_level = 5'(mq.size());
            checks += 9;
            if (m_valid !== exp_valid) begin errors++; $display("FAIL rand_valid cyc %0d: got %b expected %b", i, m_valid, exp_valid); end
            if (m_data !== exp_data) begin errors++; $display("FAIL rand_data cyc %0d: got %0h expected %0h", i, m_data, exp_data); end
            if (m_ts !== exp_ts) begin errors++; $display("FAIL rand_ts cyc %0d: got %0h expected %0h", i, m_ts, exp_ts); end
            if (level !== exp_level) begin errors++; $display("FAIL rand_level cyc %0d: got %0d expected %0d", i, level, exp_level); end
            if (full !== (exp_level == 5'd16)) begin errors++; $display("FAIL rand_full cyc %0d: got %b expected %b", i, full, exp_level == 5'd16); end
            if (empty !== (exp_level == 5'd0)) begin errors++; $display("FAIL rand_empty cyc %0d: got %b expected %b", i, empty, exp_level == 5'd0); end
            if (overflow_cnt !== ovf_model) begin errors++; $display("FAIL rand_ovf cyc %0d: got %0d expected %0d", i, overflow_cnt, ovf_model); end
            if (busy !== (mode != M_IDLE)) begin errors++; $display("FAIL rand_busy cyc %0d: got %b expected %b", i, busy, mode != M_IDLE); end
            if (dut.m_valid !== (level != 5'd0)) begin errors++; $display("FAIL rand_valid_level cyc %0d: got %b level %0d", i, m_valid, level); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_async_reset();
        test_timestamp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_capture_buffer.md
# sample_capture_buffer

Captures one input data word on every sample clock-enable pulse from the sample CE generator and queues it in a small FIFO. Presents queued samples downstream on a valid/ready stream. Sits directly downstream of the CE generator, between the sampled data source and the processing/DMA path. Drops samples when full and counts the drops so software can detect overrun.

## Interface
- DWIDTH, 16, width of captured sample word
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 entries (16)
- TS_WIDTH, 32, timestamp width (used only with timestamp feature)
- clk  in  1  single clock for all logic
- rst  in  1  reset, asynchronous, active-high
- sample_ce  in  1  one-cycle capture strobe from CE generator
- sample_data  in  DWIDTH  data word sampled when sample_ce=1
- enable  in  1  capture enable from software
- m_valid  out  1  output word available
- m_ready  in  1  downstream accepts word
- m_data  out  DWIDTH  head-of-FIFO sample
- m_ts  out  TS_WIDTH  head-of-FIFO timestamp (0 when feature compiled out)
- level  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
- full  out  1  level == 2^DEPTH_LOG2
- empty  out  1  level == 0
- overflow_cnt  out  16  dropped-sample count, saturating
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RUN, FLUSH. Reset -> IDLE.
- IDLE: no captures. enable=1 -> RUN.
- RUN: sample_ce=1 captures sample_data (and timestamp) into FIFO. enable=0 -> FLUSH. A sample_ce in the same cycle enable falls is still captured.
- FLUSH: no captures. Stream continues draining. Leave for IDLE the cycle after level reaches 0. enable is ignored in FLUSH; re-arm happens only through IDLE.
- Write condition: state==RUN && sample_ce && (!full || pop). Pop = m_valid && m_ready.
- Simultaneous push and pop when full: both occur, level stays 2^DEPTH_LOG2, no drop.
- Drop: state==RUN && sample_ce && full && !pop. overflow_cnt += 1 and saturates at 16'hFFFF. Cleared only by rst.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. level updates +1 on push only, -1 on pop only, unchanged on both or neither.
- Stream rules: m_valid = !empty. While m_valid && !m_ready, m_data/m_ts hold stable. m_valid never deasserts without a pop.
- Output is first-word-fall-through: m_data reflects the entry at the read pointer.

## Timing
- Reset values: m_valid=0, m_data=0, m_ts=0, level=0, full=0, empty=1, overflow_cnt=0, busy=0. Storage contents are don't-care.
- Reset mid-operation discards all queued samples immediately (asynchronous).
- Capture latency: sample_ce high at edge N -> m_valid=1, m_data=sample after edge N (visible in cycle N+1).
- Pop at edge N -> next entry (or m_valid=0) after edge N.
- level/full/empty/overflow_cnt are registered and update at the same edge as the push/pop/drop.
- IDLE->RUN: enable sampled at edge N. The first capturable sample_ce is in cycle N+1.
- Throughput: one push and one pop per cycle.

## Configuration
- SAMPLE_CAPTURE_TIMESTAMP_EN defined: a TS_WIDTH free-running cycle counter runs from reset (reset value 0, wraps). Its value at the capture edge is stored alongside each sample and presented on m_ts with m_data.
- Not defined: no counter and no timestamp storage. m_ts is tied to 0. All other behaviour is identical.

## Test plan
- Basic: enable=1, sample_ce every 10 cycles with data 0x0001..0x0005, m_ready=1 -> five beats 0x0001..0x0005 in order, each m_valid one cycle after its ce; level never exceeds 1.
- Overflow: m_ready=0, 20 ce pulses, data 0..19 -> full=1 after 16th, overflow_cnt=4; then m_ready=1 drains 0..15 exactly.
- Full push+pop: at level=16, sample_ce and pop in same cycle -> level stays 16, overflow_cnt unchanged, new word appears as 16th entry.
- Flush: 3 queued, enable=0, m_ready=1 -> 3 beats, busy falls one cycle after empty; ce pulses during FLUSH are not captured and do not increment overflow_cnt.
- Async reset: rst pulsed mid-cycle with level=7 -> m_valid=0, level=0, overflow_cnt=0 without waiting for a clk edge; state IDLE.
- Timestamp (macro on): ce at cycles 100 and 130 after reset -> m_ts values differ by exactly 30; with macro off m_ts=0 throughout.
